// File: rtl/audio_pkg.sv
// Shared definitions for the audio transmit path: sync marker, framer FSM states, byte-count helper.
// Latency: none (declarations only).
// Backpressure: n/a.
package audio_pkg;

  // Default frame start marker
  localparam logic [7:0] AUDIO_SYNC_BYTE = 8'hA5;

  // Framer states. CKSUM is only reachable when the checksum byte is built in.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_BYTE  = 2'd2,
    ST_CKSUM = 2'd3
  } pk_state_e;

  // Number of whole bytes needed to carry a sample of the given width
  function automatic int audio_nb(input int sample_w);
    return (sample_w + 7) / 8;
  endfunction

endpackage

// File: rtl/audio_frame_packer_if.sv
// Sample-in / byte-out bundle for the audio frame packer.
// Latency: none (wires only).
// Backpressure: sample side via o_sample_ready, byte side via i_ready.
interface audio_frame_packer_if #(
  parameter int SAMPLE_W   = 16,
  parameter int FIFO_DEPTH = 8
);

  logic [SAMPLE_W-1:0]           i_sample;
  logic                          i_sample_valid;
  logic                          o_sample_ready;
  logic                          o_drop;
  logic [$clog2(FIFO_DEPTH):0]   o_fifo_level;
  logic [7:0]                    o_data;
  logic                          o_valid;
  logic                          i_ready;

  // Environment side: offers samples, consumes bytes
  modport master (
    output i_sample, i_sample_valid, i_ready,
    input  o_sample_ready, o_drop, o_fifo_level, o_data, o_valid
  );

  // Packer side
  modport slave (
    input  i_sample, i_sample_valid, i_ready,
    output o_sample_ready, o_drop, o_fifo_level, o_data, o_valid
  );

endinterface

// File: rtl/audio_sync_fifo.sv
// Single-clock FIFO with registered full/empty/level; pointers carry one extra wrap bit.
// Latency: a pushed word is visible on o_data and counted in o_level the cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored; full blocks push even on a same-cycle pop.
module audio_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [AW:0]      level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  // Next pointers, storage and flags; flags come from the next pointers so they are exact after each edge
  always_comb begin
    do_push = i_push && !full_q;
    do_pop  = i_pop && !empty_q;
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (do_push) begin
      mem_d[wptr_q[AW-1:0]] = i_data;
      wptr_d                = wptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rptr_d = rptr_q + PTR_ONE;
    end
    level_d = wptr_d - rptr_d;
    full_d  = (level_d == LVL_FULL);
    empty_d = (level_d == '0);
  end

  // Pointer and flag registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  assign o_data  = mem_q[rptr_q[AW-1:0]];
  assign o_full  = full_q;
  assign o_empty = empty_q;
  assign o_level = level_q;

endmodule

// File: rtl/audio_frame_packer.sv
// Buffers signed PCM samples and serialises each as SYNC, sample bytes LSB first, then (AUDIO_FRAMER_CKSUM_EN) an XOR checksum byte.
// Latency: sample pushed into an empty FIFO at edge N shows SYNC on o_data/o_valid from edge N+2; frames run back-to-back.
// Backpressure: o_sample_ready = !full (overflowing samples are dropped and flagged on o_drop); bytes hold while !i_ready.
module audio_frame_packer
  import audio_pkg::*;
#(
  parameter int         SAMPLE_W   = 16,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] SYNC_BYTE  = AUDIO_SYNC_BYTE
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  audio_frame_packer_if.slave  bus
);

  localparam int            NB        = audio_nb(SAMPLE_W);
  localparam int            EXT_W     = 8 * NB;
  localparam int            CW        = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] BYTE_LAST = CW'(NB - 1);
  localparam logic [CW-1:0] BYTE_ONE  = CW'(1);

  // FIFO hookup
  logic [SAMPLE_W-1:0]           fifo_dout;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic                          fifo_pop;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level;

  // Framer state
  pk_state_e        state_q, state_d;
  logic [CW-1:0]    byte_idx_q, byte_idx_d;
  logic [EXT_W-1:0] sample_q, sample_d;     // remaining sample bytes, lowest byte next
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             drop_q, drop_d;
  logic             avail_q, avail_d;       // FIFO seen non-empty one cycle earlier
`ifdef AUDIO_FRAMER_CKSUM_EN
  logic [7:0]       cksum_q, cksum_d;
`endif

  logic             xfer;
  logic             finish;
  logic             load_next;

  audio_sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (bus.i_sample_valid),
    .i_data  (bus.i_sample),
    .i_pop   (fifo_pop),
    .o_data  (fifo_dout),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (fifo_level)
  );

  // Overflow flag and the delayed availability that gives the two-edge start latency from idle
  always_comb begin
    drop_d  = bus.i_sample_valid && fifo_full;
    avail_d = !fifo_empty;
  end

  // Framer next state: walk SYNC -> sample bytes -> optional checksum, chaining frames without a gap
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    sample_d   = sample_q;
    data_d     = data_q;
    valid_d    = valid_q;
`ifdef AUDIO_FRAMER_CKSUM_EN
    cksum_d    = cksum_q;
`endif
    fifo_pop   = 1'b0;
    finish     = 1'b0;
    load_next  = 1'b0;
    xfer       = valid_q && bus.i_ready;

    case (state_q)
      ST_IDLE: begin
        if (avail_q && !fifo_empty) begin
          load_next = 1'b1;
        end
      end
      ST_SYNC: begin
        if (xfer) begin
          state_d    = ST_BYTE;
          byte_idx_d = '0;
          data_d     = sample_q[7:0];
          sample_d   = sample_q >> 8;
`ifdef AUDIO_FRAMER_CKSUM_EN
          cksum_d    = sample_q[7:0];
`endif
        end
      end
      ST_BYTE: begin
        if (xfer) begin
          if (byte_idx_q == BYTE_LAST) begin
`ifdef AUDIO_FRAMER_CKSUM_EN
            state_d = ST_CKSUM;
            data_d  = cksum_q;
`else
            finish  = 1'b1;
`endif
          end else begin
            byte_idx_d = byte_idx_q + BYTE_ONE;
            data_d     = sample_q[7:0];
            sample_d   = sample_q >> 8;
`ifdef AUDIO_FRAMER_CKSUM_EN
            cksum_d    = cksum_q ^ sample_q[7:0];
`endif
          end
        end
      end
`ifdef AUDIO_FRAMER_CKSUM_EN
      ST_CKSUM: begin
        if (xfer) begin
          finish = 1'b1;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase

    // Final byte accepted: chain the next sample if one is waiting, else go quiet
    if (finish) begin
      if (!fifo_empty) begin
        load_next = 1'b1;
      end else begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    end

    // Frame start: pop the sample (sign-extended to whole bytes) and present the sync marker
    if (load_next) begin
      fifo_pop   = 1'b1;
      sample_d   = EXT_W'($signed(fifo_dout));
      data_d     = SYNC_BYTE;
      valid_d    = 1'b1;
      state_d    = ST_SYNC;
      byte_idx_d = '0;
    end
  end

  // Framer and flag registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      byte_idx_q <= '0;
      sample_q   <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      drop_q     <= 1'b0;
      avail_q    <= 1'b0;
`ifdef AUDIO_FRAMER_CKSUM_EN
      cksum_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      sample_q   <= sample_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      drop_q     <= drop_d;
      avail_q    <= avail_d;
`ifdef AUDIO_FRAMER_CKSUM_EN
      cksum_q    <= cksum_d;
`endif
    end
  end

  assign bus.o_sample_ready = !fifo_full;
  assign bus.o_drop         = drop_q;
  assign bus.o_fifo_level   = fifo_level;
  assign bus.o_data         = data_q;
  assign bus.o_valid        = valid_q;

endmodule
